// File: rtl/fs_scan_sequencer.sv
// Raster-order pixel job sequencer for the Floyd-Steinberg datapath: issues one pixel
// per valid/ready handshake, waits for write-back, with optional pacing, abort and frame-done pulse.
module fs_scan_sequencer #(
  parameter  int unsigned IMAGEX      = 64,
  parameter  int unsigned IMAGEY      = 64,
  parameter  int unsigned ADDR_W      = 16,
  parameter  int unsigned PACE_CYCLES = 0,
  localparam int unsigned X_W         = $clog2(IMAGEX),
  localparam int unsigned Y_W         = $clog2(IMAGEY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_pace_en,
  output logic              o_px_valid,
  input  logic              i_px_ready,
  output logic [ADDR_W-1:0] o_px_addr,
  output logic [X_W-1:0]    o_px_x,
  output logic [Y_W-1:0]    o_px_y,
  output logic [3:0]        o_edge_mask,
  input  logic              i_dp_done,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [ADDR_W-1:0] o_pixel_count
);

  localparam int unsigned PC_W      = (PACE_CYCLES > 0) ? $clog2(PACE_CYCLES + 1) : 1;
  localparam int unsigned PACE_LAST = (PACE_CYCLES > 0) ? PACE_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_PACE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [X_W-1:0]    r_x, w_x_nxt;
  logic [Y_W-1:0]    r_y, w_y_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [PC_W-1:0]   r_pace, w_pace_nxt;
  logic              r_valid, r_busy, r_frame_done;
  logic [3:0]        r_mask, w_mask_nxt;
  logic              w_last_x, w_last_y;

  assign w_last_x = (r_x == X_W'(IMAGEX - 1));
  assign w_last_y = (r_y == Y_W'(IMAGEY - 1));

  // Next-state and counter update; abort overrides every other event outside IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_pace_nxt  = r_pace;
    if ((r_state != S_IDLE) && i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            w_state_nxt = S_ISSUE;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
            w_addr_nxt  = '0;
            w_cnt_nxt   = '0;
            w_pace_nxt  = '0;
          end
        end
        S_ISSUE: begin
          if (i_px_ready) w_state_nxt = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i_dp_done) begin
            w_cnt_nxt = r_cnt + ADDR_W'(1);
            if (w_last_x && w_last_y) begin
              w_state_nxt = S_DONE;
            end else begin
              w_addr_nxt = r_addr + ADDR_W'(1);
              if (w_last_x) begin
                w_x_nxt = '0;
                w_y_nxt = r_y + Y_W'(1);
              end else begin
                w_x_nxt = r_x + X_W'(1);
              end
              if (i_pace_en && (PACE_CYCLES > 0)) begin
                w_state_nxt = S_PACE;
                w_pace_nxt  = '0;
              end else begin
                w_state_nxt = S_ISSUE;
              end
            end
          end
        end
        S_PACE: begin
          if (r_pace == PC_W'(PACE_LAST)) begin
            w_state_nxt = S_ISSUE;
            w_pace_nxt  = '0;
          end else begin
            w_pace_nxt = r_pace + PC_W'(1);
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Neighbour-existence mask for the position presented next cycle
  always_comb begin
    w_mask_nxt    = '0;
    w_mask_nxt[0] = (w_x_nxt != X_W'(IMAGEX - 1));
    w_mask_nxt[1] = (w_y_nxt != Y_W'(IMAGEY - 1)) && (w_x_nxt != '0);
    w_mask_nxt[2] = (w_y_nxt != Y_W'(IMAGEY - 1));
    w_mask_nxt[3] = (w_y_nxt != Y_W'(IMAGEY - 1)) && (w_x_nxt != X_W'(IMAGEX - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_pace       <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_mask       <= 4'b1101;
    end else begin
      r_state      <= w_state_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_addr       <= w_addr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pace       <= w_pace_nxt;
      r_valid      <= (w_state_nxt == S_ISSUE);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_frame_done <= (w_state_nxt == S_DONE);
      r_mask       <= w_mask_nxt;
    end
  end

  assign o_px_valid    = r_valid;
  assign o_px_addr     = r_addr;
  assign o_px_x        = r_x;
  assign o_px_y        = r_y;
  assign o_edge_mask   = r_mask;
  assign o_busy        = r_busy;
  assign o_frame_done  = r_frame_done;
  assign o_pixel_count = r_cnt;

endmodule

// File: tb/tb_fs_scan_sequencer.sv
// Randomized bench for fs_scan_sequencer on a 4x3 image with 3-cycle pacing,
// checked against a per-pixel raster model (index -> x, y, mask, expected gaps).
module tb_fs_scan_sequencer;

  localparam int unsigned IX   = 4;
  localparam int unsigned IY   = 3;
  localparam int unsigned AW   = 16;
  localparam int unsigned PACE = 3;
  localparam int unsigned NPIX = IX * IY;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_start = 1'b0, i_abort = 1'b0, i_pace_en = 1'b0;
  logic          i_px_ready = 1'b0, i_dp_done = 1'b0;
  logic          o_px_valid, o_busy, o_frame_done;
  logic [AW-1:0] o_px_addr, o_pixel_count;
  logic [1:0]    o_px_x, o_px_y;
  logic [3:0]    o_edge_mask;

  int n_vec = 0;
  int n_err = 0;

  fs_scan_sequencer #(.IMAGEX(IX), .IMAGEY(IY), .ADDR_W(AW), .PACE_CYCLES(PACE)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_pace_en(i_pace_en),
    .o_px_valid(o_px_valid), .i_px_ready(i_px_ready), .o_px_addr(o_px_addr),
    .o_px_x(o_px_x), .o_px_y(o_px_y), .o_edge_mask(o_edge_mask), .i_dp_done(i_dp_done),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_pixel_count(o_pixel_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model_mask(input int x, input int y);
    logic [3:0] m;
    m[0] = (x < IX - 1);
    m[1] = (y < IY - 1) && (x > 0);
    m[2] = (y < IY - 1);
    m[3] = (y < IY - 1) && (x < IX - 1);
    return m;
  endfunction

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_valid"}, 32'(o_px_valid), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_addr"}, 32'(o_px_addr), 0);
    chk({tag, "_cnt"}, 32'(o_pixel_count), 0);
    chk({tag, "_mask"}, 32'(o_edge_mask), 32'h0000_000d);
    chk({tag, "_fd"}, 32'(o_frame_done), 0);
  endtask

  // One frame; abort_idx >= 0 aborts in the cycle that pixel's dp_done arrives
  task automatic run_frame(input int abort_idx);
    int  n, guard, stall;
    bit  hs, pace_s;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("start_valid", 32'(o_px_valid), 1);
    chk("start_busy", 32'(o_busy), 1);
    chk("start_cnt", 32'(o_pixel_count), 0);
    for (int idx = 0; idx < int'(NPIX); idx++) begin
      chk("issue_valid", 32'(o_px_valid), 1);
      chk("issue_addr", 32'(o_px_addr), 32'(idx));
      chk("issue_x", 32'(o_px_x), 32'(idx % IX));
      chk("issue_y", 32'(o_px_y), 32'(idx / IX));
      chk("issue_mask", 32'(o_edge_mask), 32'(model_mask(idx % IX, idx / IX)));
      guard = 0;
      stall = 0;
      hs    = 1'b0;
      while (!hs && guard < 50) begin
        i_px_ready = (idx == 5 && stall < 5) ? 1'b0 : ($urandom_range(0, 3) != 0);
        i_dp_done  = 1'($urandom_range(0, 1));
        i_start    = 1'($urandom_range(0, 1));
        i_pace_en  = 1'($urandom_range(0, 1));
        hs = i_px_ready;
        tick();
        stall++;
        guard++;
        if (!hs) begin
          chk("stall_valid", 32'(o_px_valid), 1);
          chk("stall_addr", 32'(o_px_addr), 32'(idx));
          chk("stall_xy", {30'(0), o_px_y[0], o_px_x[0]} | 32'(o_px_y) << 8 | 32'(o_px_x) << 4,
              {30'(0), 1'((idx / IX) % 2), 1'((idx % IX) % 2)} | 32'(idx / IX) << 8 | 32'(idx % IX) << 4);
        end
      end
      i_px_ready = 1'b0;
      i_dp_done  = 1'b0;
      i_start    = 1'b0;
      if (!hs) begin
        chk("handshake_timeout", 0, 1);
        return;
      end
      chk("hs_valid_drop", 32'(o_px_valid), 0);
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        i_px_ready = 1'($urandom_range(0, 1));
        i_pace_en  = 1'($urandom_range(0, 1));
        tick();
        chk("wait_valid", 32'(o_px_valid), 0);
      end
      i_px_ready = 1'b0;
      pace_s     = 1'($urandom_range(0, 1));
      i_pace_en  = pace_s;
      i_dp_done  = 1'b1;
      if (idx == abort_idx) begin
        i_abort = 1'b1;
        i_start = 1'b1;
        tick();
        i_abort   = 1'b0;
        i_start   = 1'b0;
        i_dp_done = 1'b0;
        chk("abort_busy", 32'(o_busy), 0);
        chk("abort_valid", 32'(o_px_valid), 0);
        chk("abort_fd", 32'(o_frame_done), 0);
        chk("abort_cnt", 32'(o_pixel_count), 32'(idx));
        tick();
        chk("abort_fd2", 32'(o_frame_done), 0);
        chk("abort_busy2", 32'(o_busy), 0);
        chk("abort_cnt2", 32'(o_pixel_count), 32'(idx));
        return;
      end
      tick();
      i_dp_done = 1'b0;
      chk("done_cnt", 32'(o_pixel_count), 32'(idx + 1));
      if (idx == int'(NPIX) - 1) begin
        chk("fd_pulse", 32'(o_frame_done), 1);
        chk("fd_busy", 32'(o_busy), 1);
        chk("fd_valid", 32'(o_px_valid), 0);
        tick();
        chk("fd_end", 32'(o_frame_done), 0);
        chk("end_busy", 32'(o_busy), 0);
        tick();
        chk("hold_addr", 32'(o_px_addr), 32'(NPIX - 1));
        chk("hold_x", 32'(o_px_x), 32'(IX - 1));
        chk("hold_y", 32'(o_px_y), 32'(IY - 1));
        chk("hold_mask", 32'(o_edge_mask), 0);
        chk("hold_cnt", 32'(o_pixel_count), 32'(NPIX));
        chk("hold_fd", 32'(o_frame_done), 0);
      end else begin
        n = 1;
        while (!o_px_valid && n < 20) begin
          i_pace_en  = 1'($urandom_range(0, 1));
          i_px_ready = 1'($urandom_range(0, 1));
          i_dp_done  = 1'($urandom_range(0, 1));
          tick();
          n++;
        end
        i_px_ready = 1'b0;
        i_dp_done  = 1'b0;
        chk(pace_s ? "pace_gap_on" : "pace_gap_off", 32'(n), pace_s ? 32'(PACE + 1) : 1);
        chk("mid_fd", 32'(o_frame_done), 0);
      end
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk_idle_reset("por");
    chk("por_xy", {24'(0), 6'(0), o_px_y} | 32'(o_px_x), 0);
    #20 rst = 1'b0;
    tick();
    chk("idle_busy", 32'(o_busy), 0);

    i_start = 1'b1;
    i_abort = 1'b1;
    tick();
    i_start = 1'b0;
    i_abort = 1'b0;
    chk("start_abort_busy", 32'(o_busy), 0);
    chk("start_abort_valid", 32'(o_px_valid), 0);

    for (int f = 0; f < 4; f++) run_frame(-1);
    run_frame(7);
    run_frame(-1);
    run_frame(int'($urandom_range(0, NPIX - 1)));
    run_frame(-1);

    // Asynchronous reset mid-frame
    i_start = 1'b1;
    tick();
    i_start    = 1'b0;
    i_px_ready = 1'b1;
    tick();
    i_px_ready = 1'b0;
    i_dp_done  = 1'b1;
    tick();
    i_dp_done = 1'b0;
    chk("pre_rst_cnt", 32'(o_pixel_count), 1);
    chk("pre_rst_addr", 32'(o_px_addr), 1);
    #2 rst = 1'b1;
    #1;
    chk_idle_reset("midrst");
    #3 rst = 1'b0;
    tick();
    chk("post_rst_busy", 32'(o_busy), 0);
    chk("post_rst_fd", 32'(o_frame_done), 0);
    run_frame(-1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
